// File: rtl/strobe_gen.sv
// strobe_gen: NUM_CH independent programmable strobe generators.
// Each channel emits a one-cycle strobe every (D+1) enabled clocks.
// A new divider written to a running channel is held as pending and only
// takes effect at that channel's terminal count, so a period is never cut
// short or stretched mid-count. A disabled channel takes a write at once.
// Optional build macro: STROBE_GEN_SYNC_EN adds the i_sync input. A pulse on
// i_sync zeroes every counter and applies every pending divider, which
// phase-aligns all channels.
module strobe_gen #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
`ifdef STROBE_GEN_SYNC_EN
  input  logic                i_sync,
`endif
  input  logic [NUM_CH-1:0]   i_enable,
  input  logic                i_wr_valid,
  input  logic [CH_BITS-1:0]  i_wr_ch,
  input  logic [WIDTH-1:0]    i_wr_div,
  output logic [NUM_CH-1:0]   o_strobe,
  output logic [NUM_CH-1:0]   o_pending
);

  // Terminal count loaded at reset: period of DEFAULT_DIV clocks.
  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV - 1);

  // Reject parameter sets that cannot describe a working block.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("strobe_gen: NUM_CH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("strobe_gen: WIDTH must be >= 1");
  end
  if ((DEFAULT_DIV < 1) || ((WIDTH < 31) && (DEFAULT_DIV > (1 << WIDTH)))) begin : g_bad_default
    $error("strobe_gen: DEFAULT_DIV must be in 1 .. 2**WIDTH");
  end

  // Global realignment request; tied low when the sync feature is absent.
  logic sync_w;
`ifdef STROBE_GEN_SYNC_EN
  assign sync_w = i_sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // Declaration initialisers equal the reset values so the block counts
    // sensibly even if reset is never asserted.
    logic [WIDTH-1:0] counter_q     = '0;
    logic [WIDTH-1:0] div_active_q  = DIV_INIT;
    logic [WIDTH-1:0] div_pending_q = '0;
    logic             pend_valid_q  = 1'b0;

    logic [WIDTH-1:0] counter_d;
    logic [WIDTH-1:0] div_active_d;
    logic [WIDTH-1:0] div_pending_d;
    logic             pend_valid_d;

    logic wr_hit;
    logic at_terminal;

    // Only a code equal to this channel's index hits it, so codes at or
    // beyond NUM_CH fall through every channel and are ignored.
    assign wr_hit      = i_wr_valid && (i_wr_ch == CH_BITS'(gi));
    assign at_terminal = (counter_q == div_active_q);

    // Strobe is combinational from state and enable; silent in reset and
    // in a sync cycle.
    assign o_strobe[gi]  = !i_reset && !sync_w && i_enable[gi] && at_terminal;
    assign o_pending[gi] = !i_reset && pend_valid_q;

    // Next-state: idle/sync path applies everything at once, running path
    // defers divider changes to the terminal count.
    always_comb begin
      counter_d     = counter_q;
      div_active_d  = div_active_q;
      div_pending_d = div_pending_q;
      pend_valid_d  = pend_valid_q;

      if (sync_w || !i_enable[gi]) begin
        // Channel is parked at zero, so a divider swap cannot glitch.
        // A same-cycle write is newer than the pending value and wins.
        counter_d    = '0;
        pend_valid_d = 1'b0;
        if (pend_valid_q) begin
          div_active_d = div_pending_q;
        end
        if (wr_hit) begin
          div_active_d = i_wr_div;
        end
      end else begin
        if (at_terminal) begin
          counter_d = '0;
          if (pend_valid_q) begin
            div_active_d = div_pending_q;
            pend_valid_d = 1'b0;
          end
        end else begin
          counter_d = counter_q + 1'b1;
        end
        // A write landing on the terminal cycle is not bypassed: it waits
        // a full period behind whatever was applied this cycle.
        if (wr_hit) begin
          div_pending_d = i_wr_div;
          pend_valid_d  = 1'b1;
        end
      end
    end

    // Channel state registers with synchronous reset; writes in a reset
    // cycle are dropped because the reset branch ignores the _d values.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        counter_q     <= '0;
        div_active_q  <= DIV_INIT;
        div_pending_q <= '0;
        pend_valid_q  <= 1'b0;
      end else begin
        counter_q     <= counter_d;
        div_active_q  <= div_active_d;
        div_pending_q <= div_pending_d;
        pend_valid_q  <= pend_valid_d;
      end
    end
  end

endmodule

// File: tb/tb_strobe_gen.sv
// tb_strobe_gen: directed self-checking bench for strobe_gen.
// Main DUT uses default parameters (4 channels, 16 bits, period 10).
// A second 5-channel instance (3-bit channel select, period 3) gives
// representable out-of-range channel codes.
// Build with STROBE_GEN_SYNC_EN defined to also exercise i_sync.
module tb_strobe_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [3:0]  en;
  logic        wr_valid;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic [3:0]  strobe;
  logic [3:0]  pending;

  logic [4:0]  en5;
  logic        wr_valid5;
  logic [2:0]  wr_ch5;
  logic [3:0]  wr_div5;
  logic [4:0]  strobe5;
  logic [4:0]  pending5;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  strobe_gen u_dut (
    .i_clk      (clk),
    .i_reset    (rst),
`ifdef STROBE_GEN_SYNC_EN
    .i_sync     (sync),
`endif
    .i_enable   (en),
    .i_wr_valid (wr_valid),
    .i_wr_ch    (wr_ch),
    .i_wr_div   (wr_div),
    .o_strobe   (strobe),
    .o_pending  (pending)
  );

  strobe_gen #(.NUM_CH(5), .WIDTH(4), .DEFAULT_DIV(3)) u_dut5 (
    .i_clk      (clk),
    .i_reset    (rst),
`ifdef STROBE_GEN_SYNC_EN
    .i_sync     (sync),
`endif
    .i_enable   (en5),
    .i_wr_valid (wr_valid5),
    .i_wr_ch    (wr_ch5),
    .i_wr_div   (wr_div5),
    .o_strobe   (strobe5),
    .o_pending  (pending5)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle; on return the current cycle is t=0 with counters 0.
  task automatic do_reset();
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_valid5 = 1'b0;
    sync      = 1'b0;
    clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_s;
    en       = 4'hF;
    rst      = 1'b1;
    wr_valid = 1'b0;
    #1;
    tests_run++;
    if (strobe !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_strobe got %b want 0000", strobe);
    end
    tests_run++;
    if (pending !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_pending got %b want 0000", pending);
    end
    clk_step();
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      #1;
      exp_s = ((t % 10) == 9) ? 4'hF : 4'h0;
      tests_run++;
      if (strobe !== exp_s || pending !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset_default t=%0d strobe=%b pending=%b want strobe=%b pending=0000",
                 t, strobe, pending, exp_s);
      end
      clk_step();
    end
  endtask

  task automatic test_reprogram();
    logic [3:0] exp_s;
    logic [3:0] exp_p;
    en = 4'hF;
    do_reset();
    for (int t = 0; t < 22; t++) begin
      wr_valid = (t == 4);
      wr_ch    = 2'd1;
      wr_div   = 16'd3;
      #1;
      exp_s = ((t % 10) == 9) ? 4'b1101 : 4'b0000;
      if (t <= 9) exp_s[1] = (t == 9);
      else        exp_s[1] = (((t - 10) % 4) == 3);
      exp_p = (t >= 5 && t <= 9) ? 4'b0010 : 4'b0000;
      tests_run++;
      if (strobe !== exp_s || pending !== exp_p) begin
        tests_failed++;
        $display("FAIL reprogram t=%0d strobe=%b pending=%b want strobe=%b pending=%b",
                 t, strobe, pending, exp_s, exp_p);
      end
      clk_step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [3:0] exp_s;
    logic [3:0] exp_p;
    en = 4'h0;
    do_reset();
    for (int t = 0; t < 17; t++) begin
      en       = (t >= 1) ? 4'b0001 : 4'b0000;
      wr_valid = (t == 0) || (t == 5);
      wr_ch    = 2'd0;
      wr_div   = (t == 0) ? 16'd4 : 16'd1;
      #1;
      exp_s = 4'b0000;
      exp_s[0] = (t == 5) || (t == 10) || (t == 12) || (t == 14) || (t == 16);
      exp_p = (t >= 6 && t <= 10) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (strobe !== exp_s || pending !== exp_p) begin
        tests_failed++;
        $display("FAIL same_cycle t=%0d strobe=%b pending=%b want strobe=%b pending=%b",
                 t, strobe, pending, exp_s, exp_p);
      end
      clk_step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_disabled_write();
    logic       en3_pat [0:8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_s;
    en = 4'h0;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      wr_valid = (t <= 1);
      wr_ch    = (t == 0) ? 2'd2 : 2'd3;
      wr_div   = 16'd0;
      en       = {en3_pat[t], (t >= 2), 2'b00};
      #1;
      exp_s = {en3_pat[t], (t >= 2), 2'b00};
      tests_run++;
      if (strobe !== exp_s || pending !== 4'h0) begin
        tests_failed++;
        $display("FAIL disabled_write t=%0d strobe=%b pending=%b want strobe=%b pending=0000",
                 t, strobe, pending, exp_s);
      end
      clk_step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_s;
    logic [3:0] exp_p;
    en = 4'b0001;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      wr_valid = (t == 1) || (t == 2);
      wr_ch    = 2'd0;
      wr_div   = (t == 1) ? 16'd5 : 16'd1;
      en       = (t == 4) ? 4'b0000 : 4'b0001;
      #1;
      exp_s = {3'b000, ((t == 6) || (t == 8))};
      exp_p = {3'b000, (t >= 2 && t <= 4)};
      tests_run++;
      if (strobe !== exp_s || pending !== exp_p) begin
        tests_failed++;
        $display("FAIL enable_drop t=%0d strobe=%b pending=%b want strobe=%b pending=%b",
                 t, strobe, pending, exp_s, exp_p);
      end
      clk_step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_s;
    logic [3:0] exp_p;
    en = 4'b0001;
    do_reset();
    for (int t = 0; t < 27; t++) begin
      rst      = (t == 6);
      wr_valid = (t == 3);
      wr_ch    = 2'd0;
      wr_div   = 16'd2;
      #1;
      exp_s = {3'b000, ((t == 16) || (t == 26))};
      exp_p = {3'b000, (t == 4 || t == 5)};
      tests_run++;
      if (strobe !== exp_s || pending !== exp_p) begin
        tests_failed++;
        $display("FAIL reset_mid t=%0d strobe=%b pending=%b want strobe=%b pending=%b",
                 t, strobe, pending, exp_s, exp_p);
      end
      clk_step();
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic test_invalid_channel();
    logic [4:0] exp_s;
    en  = 4'h0;
    en5 = 5'h1F;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      wr_valid5 = (t <= 1);
      wr_ch5    = (t == 0) ? 3'd5 : 3'd7;
      wr_div5   = 4'd0;
      #1;
      exp_s = ((t % 3) == 2) ? 5'h1F : 5'h00;
      tests_run++;
      if (strobe5 !== exp_s || pending5 !== 5'h00) begin
        tests_failed++;
        $display("FAIL invalid_channel t=%0d strobe=%b pending=%b want strobe=%b pending=00000",
                 t, strobe5, pending5, exp_s);
      end
      clk_step();
    end
    wr_valid5 = 1'b0;
    en5       = 5'h00;
  endtask

`ifdef STROBE_GEN_SYNC_EN
  task automatic test_sync();
    logic [3:0] exp_s;
    logic [3:0] exp_p;
    en = 4'hF;
    do_reset();
    for (int t = 0; t < 14; t++) begin
      wr_valid = (t <= 3) || (t == 5);
      wr_ch    = (t <= 3) ? 2'(t) : 2'd2;
      wr_div   = (t <= 3) ? 16'd3 : 16'd1;
      sync     = (t == 5);
      #1;
      exp_s = 4'b0000;
      if (t >= 6) begin
        if (t == 9 || t == 13) exp_s = 4'hF;
        if (t >= 7 && (t % 2) == 1) exp_s[2] = 1'b1;
      end
      case (t)
        1:       exp_p = 4'b0001;
        2:       exp_p = 4'b0011;
        3:       exp_p = 4'b0111;
        4, 5:    exp_p = 4'b1111;
        default: exp_p = 4'b0000;
      endcase
      tests_run++;
      if (strobe !== exp_s || pending !== exp_p) begin
        tests_failed++;
        $display("FAIL sync t=%0d strobe=%b pending=%b want strobe=%b pending=%b",
                 t, strobe, pending, exp_s, exp_p);
      end
      clk_step();
    end
    wr_valid = 1'b0;
    sync     = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    sync      = 1'b0;
    en        = 4'h0;
    wr_valid  = 1'b0;
    wr_ch     = 2'd0;
    wr_div    = 16'd0;
    en5       = 5'h00;
    wr_valid5 = 1'b0;
    wr_ch5    = 3'd0;
    wr_div5   = 4'd0;
    clk_step();

    test_reset();
    test_reprogram();
    test_same_cycle();
    test_disabled_write();
    test_enable_drop();
    test_reset_mid();
    test_invalid_channel();
`ifdef STROBE_GEN_SYNC_EN
    test_sync();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
